// File: rtl/dbg_trace_pkg.sv
// dbg_trace_pkg
// Shared definitions for the debug trace path: default record and drop
// counter widths, field offsets inside one trace record, the default-sized
// per-core holding slot record and the output scheduler state encoding.
package dbg_trace_pkg;

  localparam int TRACE_W_DEF = 103;
  localparam int DROP_W_DEF  = 8;

  // Trace record layout: [63:0] pc, [95:64] timestamp, [102:96] event kind
  localparam int TR_PC_LSB   = 0;
  localparam int TR_PC_W     = 64;
  localparam int TR_TS_LSB   = 64;
  localparam int TR_TS_W     = 32;
  localparam int TR_KIND_LSB = 96;
  localparam int TR_KIND_W   = 7;

  // One holding slot at default widths
  typedef struct packed {
    logic                  full;
    logic [TRACE_W_DEF-1:0] data;
    logic [DROP_W_DEF-1:0]  drops;
  } trace_slot_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/trace_rr_arb.sv
// trace_rr_arb
// Round-robin arbiter. Grants the first asserted request at an index at or
// above the internal pointer, wrapping modulo N. The pointer moves to one
// past the granted index whenever en is high and a grant exists.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req[N]      request vector
//   en          a grant is being consumed this cycle (advance pointer)
//   gnt_idx     granted index (valid when gnt_valid)
//   gnt_valid   at least one request is asserted
module trace_rr_arb #(
  parameter int N    = 16,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            en,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_valid
);

  localparam logic [ID_W:0]   N_EXT = (ID_W+1)'(N);
  localparam logic [ID_W-1:0] LAST  = ID_W'(N-1);

  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   cand;

  // Walk the requests starting at ptr; the extra candidate bit lets the
  // wrap work for N that is not a power of two.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!gnt_valid && req[cand[ID_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && gnt_valid) begin
      ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/trace_stream_sched.sv
// trace_stream_sched
// Merges per-core trace streams onto one sink. Each core owns a one-entry
// slot; strobes that find the slot occupied are dropped and counted, and the
// count is delivered with that core's next record. Slots drain round-robin
// into a registered output stage with valid/ready handshake.
// Ports:
//   clk, rst_sys_n  clock, asynchronous active-low reset
//   trace_valid     per-core record strobe
//   trace_data      per-core records, core i at [(i+1)*TRACE_W-1 : i*TRACE_W]
//   core_enable     per-core capture mask
//   out_valid       output record valid
//   out_ready       sink accepts the output record
//   out_core        source core of the output record
//   out_data        output record
//   out_drops       records lost from out_core before this one (saturating)
module trace_stream_sched
  import dbg_trace_pkg::*;
#(
  parameter int NUMCORES = 16,
  parameter int TRACE_W  = TRACE_W_DEF,
  parameter int DROP_W   = DROP_W_DEF,
  parameter int ID_W     = $clog2(NUMCORES)
) (
  input  logic                        clk,
  input  logic                        rst_sys_n,
  input  logic [NUMCORES-1:0]         trace_valid,
  input  logic [NUMCORES*TRACE_W-1:0] trace_data,
  input  logic [NUMCORES-1:0]         core_enable,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ID_W-1:0]             out_core,
  output logic [TRACE_W-1:0]          out_data,
  output logic [DROP_W-1:0]           out_drops
);

  typedef struct packed {
    logic               full;
    logic [TRACE_W-1:0] data;
    logic [DROP_W-1:0]  drops;
  } slot_t;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  sched_state_e                     state;
  logic [NUMCORES-1:0]              slot_full;
  logic [NUMCORES-1:0][TRACE_W-1:0] slot_data;
  logic [NUMCORES-1:0][DROP_W-1:0]  slot_drops;
  logic [NUMCORES-1:0]              pop;
  logic                             load_en;
  logic                             gnt_valid;
  logic [ID_W-1:0]                  gnt_idx;

  // The output register can take a new record when it is empty or the sink
  // is consuming the current one this cycle.
  assign load_en = (state == ST_EMPTY) || out_ready;

  trace_rr_arb #(
    .N    (NUMCORES),
    .ID_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_sys_n),
    .req       (slot_full),
    .en        (load_en),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    pop = '0;
    if (load_en && gnt_valid) pop[gnt_idx] = 1'b1;
  end

  for (genvar g = 0; g < NUMCORES; g++) begin : g_slot
    slot_t slot_q;
    logic  capture;

    assign capture       = trace_valid[g] & core_enable[g];
    assign slot_full[g]  = slot_q.full;
    assign slot_data[g]  = slot_q.data;
    assign slot_drops[g] = slot_q.drops;

    // A slot being popped this cycle can accept a new record in the same
    // cycle, so a pop and a drop on the same core never coincide.
    always_ff @(posedge clk or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
        slot_q <= '0;
      end else begin
        if (capture && (!slot_q.full || pop[g])) begin
          slot_q.full <= 1'b1;
          slot_q.data <= trace_data[g*TRACE_W +: TRACE_W];
        end else if (pop[g]) begin
          slot_q.full <= 1'b0;
        end
        if (pop[g]) begin
          slot_q.drops <= '0;
        end else if (capture && slot_q.full && (slot_q.drops != DROP_MAX)) begin
          slot_q.drops <= slot_q.drops + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_core  <= '0;
      out_data  <= '0;
      out_drops <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (gnt_valid) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            out_core  <= gnt_idx;
            out_data  <= slot_data[gnt_idx];
            out_drops <= slot_drops[gnt_idx];
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            if (gnt_valid) begin
              out_core  <= gnt_idx;
              out_data  <= slot_data[gnt_idx];
              out_drops <= slot_drops[gnt_idx];
            end else begin
              state     <= ST_EMPTY;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_stream_sched.sv
module tb_trace_stream_sched;

  localparam int N  = 16;
  localparam int TW = 103;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int DROP_SAT = 255;

  logic              clk = 1'b0;
  logic              rst_sys_n;
  logic [N-1:0]      trace_valid;
  logic [N*TW-1:0]   trace_data;
  logic [N-1:0]      core_enable;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     out_core;
  logic [TW-1:0]     out_data;
  logic [DW-1:0]     out_drops;

  logic [TW-1:0]     core_data [N];

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit            m_full  [N];
  logic [TW-1:0] m_data  [N];
  int            m_drops [N];
  int            m_ptr;
  bit            m_valid;
  int            m_core;
  logic [TW-1:0] m_out_data;
  int            m_out_drops;

  typedef struct {
    int            core;
    logic [TW-1:0] data;
    logic          rdy;
    logic          exp_valid;
    int            exp_core;
    logic [TW-1:0] exp_data;
    int            exp_drops;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) trace_data[i*TW +: TW] = core_data[i];
  end

  trace_stream_sched dut (
    .clk         (clk),
    .rst_sys_n   (rst_sys_n),
    .trace_valid (trace_valid),
    .trace_data  (trace_data),
    .core_enable (core_enable),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_core    (out_core),
    .out_data    (out_data),
    .out_drops   (out_drops)
  );

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_data[i] = '0; m_drops[i] = 0;
    end
    m_ptr = 0; m_valid = 0; m_core = 0; m_out_data = '0; m_out_drops = 0;
  endtask

  // One clock of the scheduler rules: output stage takes the first full slot
  // from ptr onward if it is free or being consumed, then captures apply.
  task automatic modelStep();
    int grant;
    int k;
    bit load_ok;
    load_ok = !m_valid || out_ready;
    grant = -1;
    for (int off = 0; off < N; off++) begin
      k = (m_ptr + off) % N;
      if (grant < 0 && m_full[k]) grant = k;
    end
    if (load_ok) begin
      if (grant >= 0) begin
        m_valid = 1; m_core = grant;
        m_out_data = m_data[grant]; m_out_drops = m_drops[grant];
        m_ptr = (grant + 1) % N;
        m_full[grant] = 0; m_drops[grant] = 0;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (trace_valid[i] && core_enable[i]) begin
        if (!m_full[i]) begin
          m_full[i] = 1; m_data[i] = core_data[i];
        end else if (m_drops[i] < DROP_SAT) begin
          m_drops[i]++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] tv, input logic rdy);
    trace_valid = tv;
    out_ready   = rdy;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_valid"}, out_valid, m_valid);
    if (m_valid) begin
      checkVal({tag, "_core"}, out_core, m_core);
      checkVal({tag, "_data"}, out_data, m_out_data);
      checkVal({tag, "_drops"}, out_drops, m_out_drops);
    end
  endtask

  task automatic resetDut();
    rst_sys_n   = 1'b0;
    trace_valid = '0;
    out_ready   = 1'b0;
    core_enable = '1;
    for (int i = 0; i < N; i++) core_data[i] = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    rst_sys_n = 1'b1;
    checkVal("reset_valid", out_valid, 0);
    checkVal("reset_core", out_core, 0);
    checkVal("reset_data", out_data, 0);
    checkVal("reset_drops", out_drops, 0);
  endtask

  task automatic applyVec(input vec_t v, input string tag);
    logic [N-1:0] tv;
    tv = '0;
    if (v.core >= 0) begin
      tv[v.core] = 1'b1;
      core_data[v.core] = v.data;
    end
    applyStimulus(tv, v.rdy);
    checkOutput({tag, "_model"});
    checkVal({tag, "_valid"}, out_valid, v.exp_valid);
    if (v.exp_valid) begin
      checkVal({tag, "_core"}, out_core, v.exp_core);
      checkVal({tag, "_data"}, out_data, v.exp_data);
      checkVal({tag, "_drops"}, out_drops, v.exp_drops);
    end
  endtask

  initial begin
    logic [127:0] r;
    logic [N-1:0] b7;

    // single record on core 5, latency two cycles
    vecs[0] = '{5,  'hABC, 1'b1, 1'b0, 0, '0,    0};
    vecs[1] = '{-1, '0,    1'b1, 1'b1, 5, 'hABC, 0};
    vecs[2] = '{-1, '0,    1'b1, 1'b0, 0, '0,    0};
    vecs[3] = '{-1, '0,    1'b1, 1'b0, 0, '0,    0};
    // core 2 strobes four times while the sink stalls
    vecs[4] = '{2,  'h1,   1'b0, 1'b0, 0, '0,    0};
    vecs[5] = '{2,  'h2,   1'b0, 1'b1, 2, 'h1,   0};
    vecs[6] = '{2,  'h3,   1'b0, 1'b1, 2, 'h1,   0};
    vecs[7] = '{2,  'h4,   1'b0, 1'b1, 2, 'h1,   0};
    vecs[8] = '{-1, '0,    1'b1, 1'b1, 2, 'h2,   2};
    vecs[9] = '{-1, '0,    1'b1, 1'b0, 0, '0,    0};

    resetDut();
    for (int i = 0; i < 4; i++) applyVec(vecs[i], $sformatf("single%0d", i));
    resetDut();
    for (int i = 4; i < 10; i++) applyVec(vecs[i], $sformatf("drop2_%0d", i));

    // all cores strobe together: drained in index order
    resetDut();
    for (int i = 0; i < N; i++) core_data[i] = TW'(i + 'h100);
    applyStimulus('1, 1'b1);
    checkVal("all16_first", out_valid, 0);
    for (int k = 0; k < N; k++) begin
      applyStimulus('0, 1'b1);
      checkOutput("all16_model");
      checkVal("all16_valid", out_valid, 1);
      checkVal("all16_core", out_core, k);
      checkVal("all16_data", out_data, k + 'h100);
      checkVal("all16_drops", out_drops, 0);
    end
    applyStimulus('0, 1'b1);
    checkVal("all16_end", out_valid, 0);

    // drop counter saturation on core 3
    resetDut();
    for (int c = 0; c < 300; c++) begin
      core_data[3] = TW'(c);
      applyStimulus(N'(1) << 3, 1'b0);
      checkOutput("sat_model");
    end
    checkVal("sat_first_core", out_core, 3);
    checkVal("sat_first_drops", out_drops, 0);
    applyStimulus('0, 1'b1);
    checkOutput("sat_model");
    checkVal("sat_second_valid", out_valid, 1);
    checkVal("sat_second_core", out_core, 3);
    checkVal("sat_second_drops", out_drops, DROP_SAT);

    // fairness between two always-busy cores
    resetDut();
    for (int c = 0; c < 20; c++) begin
      core_data[0] = TW'(c);
      core_data[1] = TW'(c + 1000);
      applyStimulus(N'(3), 1'b1);
      checkOutput("fair_model");
      if (c == 0) checkVal("fair_first", out_valid, 0);
      else begin
        checkVal("fair_valid", out_valid, 1);
        checkVal("fair_core", out_core, (c - 1) % 2);
      end
    end

    // core_enable blocks captures but a held slot still drains
    resetDut();
    b7 = N'(1) << 7;
    core_data[7] = TW'('hA1);
    applyStimulus(b7, 1'b0);
    checkVal("en_a_pending", out_valid, 0);
    core_data[7] = TW'('hB2);
    applyStimulus(b7, 1'b0);
    checkVal("en_a_data", out_data, 'hA1);
    core_data[7] = TW'('hC3);
    applyStimulus(b7, 1'b0);
    core_enable[7] = 1'b0;
    core_data[7] = TW'('hD4);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(b7, 1'b0);
      checkOutput("en_off_model");
      checkVal("en_off_hold", out_data, 'hA1);
    end
    applyStimulus('0, 1'b1);
    checkVal("en_drain_core", out_core, 7);
    checkVal("en_drain_data", out_data, 'hB2);
    checkVal("en_drain_drops", out_drops, 1);
    applyStimulus('0, 1'b1);
    checkVal("en_drain_end", out_valid, 0);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(b7, 1'b1);
      checkVal("en_off_ignored", out_valid, 0);
    end
    core_enable[7] = 1'b1;
    core_data[7] = TW'('hE5);
    applyStimulus(b7, 1'b1);
    applyStimulus('0, 1'b1);
    checkOutput("en_on_model");
    checkVal("en_on_data", out_data, 'hE5);
    checkVal("en_on_drops", out_drops, 0);

    // reset in the middle of a burst
    resetDut();
    for (int i = 0; i < N; i++) core_data[i] = TW'(i + 'h300);
    for (int c = 0; c < 3; c++) begin
      applyStimulus('1, 1'b1);
      checkOutput("burst_model");
    end
    #2;
    rst_sys_n = 1'b0;
    #1;
    checkVal("midrst_valid", out_valid, 0);
    checkVal("midrst_core", out_core, 0);
    checkVal("midrst_drops", out_drops, 0);
    modelReset();
    trace_valid = '0;
    @(posedge clk);
    #2;
    rst_sys_n = 1'b1;
    for (int i = 0; i < 4; i++) applyVec(vecs[i], $sformatf("postrst%0d", i));

    // randomized traffic against the model
    resetDut();
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] tv;
      for (int i = 0; i < N; i++) begin
        tv[i] = ($urandom_range(0, 3) == 0);
        core_enable[i] = ($urandom_range(0, 15) != 0);
        r = {$urandom, $urandom, $urandom, $urandom};
        core_data[i] = r[TW-1:0];
      end
      applyStimulus(tv, $urandom_range(0, 9) < 7);
      checkOutput("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
